// File: rtl/demux_l2_pkg.sv
// demux_l2_pkg: lane count, pointer width and group layout shared with the mux-tree benches.
package demux_l2_pkg;
  localparam int LANES = 4;
  localparam int PTR_W = 2;
  localparam int GROUP_DATA_W = 8;
  // Lane 0 occupies the least significant byte.
  typedef logic [LANES-1:0][GROUP_DATA_W-1:0] group_t;
endpackage

// File: rtl/demux_l2_group_fifo.sv
// group_fifo: synchronous FIFO of assembled groups; a pop frees room for a same-cycle push even when full.
module group_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          cclk,
  input  logic          reset_L,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  always_comb begin
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge cclk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= wdata;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/demux_l2.sv
// demux_l2: de-interleaves a round-robin byte stream into 4-lane groups queued in an output FIFO.
module demux_l2
  import demux_l2_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 2
) (
  input  logic                     cclk,
  input  logic                     reset_L,
  input  logic                     valid_in,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     pop,
  output logic                     valid_out,
  output logic [DATA_W-1:0]        data_out0,
  output logic [DATA_W-1:0]        data_out1,
  output logic [DATA_W-1:0]        data_out2,
  output logic [DATA_W-1:0]        data_out3,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [PTR_W-1:0]         lane_ptr,
  output logic                     overflow
);
  logic [PTR_W-1:0] lane_q, lane_d;
  logic [DATA_W-1:0] slot_q [LANES];
  logic ovf_q, ovf_d, push, full, empty;
  logic [LANES*DATA_W-1:0] wgroup, rgroup;
  assign push = valid_in && lane_q == PTR_W'(LANES-1);
  // The last byte bypasses its slot and goes straight into the pushed group.
  assign wgroup = {data_in, slot_q[2], slot_q[1], slot_q[0]};
  always_comb begin
    lane_d = valid_in ? lane_q + 1'b1 : lane_q;
    ovf_d = ovf_q | (push & full & ~pop);
  end
  always_ff @(posedge cclk or negedge reset_L) begin
    if (!reset_L) begin
      lane_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < LANES; i++) slot_q[i] <= '0;
    end else begin
      if (valid_in) slot_q[lane_q] <= data_in;
      lane_q <= lane_d;
      ovf_q <= ovf_d;
    end
  end
  group_fifo #(.W(LANES*DATA_W), .DEPTH(DEPTH)) u_fifo (
    .cclk    (cclk),
    .reset_L (reset_L),
    .push    (push),
    .pop     (pop),
    .wdata   (wgroup),
    .rdata   (rgroup),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );
  assign valid_out = ~empty;
  assign {data_out3, data_out2, data_out1, data_out0} = rgroup;
  assign lane_ptr = lane_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_demux_l2.sv
// tb_demux_l2: directed and randomized checks of demux_l2 against a queue-based model.
module tb_demux_l2;
  localparam int DEPTH = 2;
  logic cclk = 0, reset_L = 1, valid_in = 0, pop = 0;
  logic [7:0] data_in = 0;
  logic valid_out, overflow;
  logic [7:0] data_out0, data_out1, data_out2, data_out3;
  logic [1:0] fifo_count, lane_ptr;
  int checks = 0, failures = 0;
  logic [31:0] mq [$];
  logic [7:0] part [4];
  int mptr = 0;
  bit movf = 0;
  bit pushg;
  logic [31:0] g;

  demux_l2 #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .cclk(cclk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in), .pop(pop),
    .valid_out(valid_out), .data_out0(data_out0), .data_out1(data_out1),
    .data_out2(data_out2), .data_out3(data_out3), .fifo_count(fifo_count),
    .lane_ptr(lane_ptr), .overflow(overflow)
  );

  always #5 cclk = ~cclk;

  // Model: partial bytes, a pointer counting modulo 4 and a bounded queue of groups.
  always @(posedge cclk or negedge reset_L) begin
    if (!reset_L) begin
      mq.delete();
      mptr = 0;
      movf = 0;
    end else begin
      pushg = valid_in && mptr == 3;
      g = {data_in, part[2], part[1], part[0]};
      if (valid_in) begin
        part[mptr] = data_in;
        mptr = (mptr + 1) % 4;
      end
      if (pop && mq.size() > 0) void'(mq.pop_front());
      if (pushg) begin
        if (mq.size() < DEPTH) mq.push_back(g);
        else movf = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge cclk) begin
    if (reset_L) begin
      chk("m_valid_out", 32'(valid_out), 32'(mq.size() > 0));
      chk("m_fifo_count", 32'(fifo_count), 32'(mq.size()));
      chk("m_lane_ptr", 32'(lane_ptr), 32'(mptr));
      chk("m_overflow", 32'(overflow), 32'(movf));
      if (mq.size() > 0) chk("m_data", {data_out3, data_out2, data_out1, data_out0}, mq[0]);
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic p);
    @(negedge cclk);
    valid_in = v;
    data_in = d;
    pop = p;
  endtask

  task automatic grp(input logic [31:0] x, input logic plast);
    cyc(1, x[7:0], 0);
    cyc(1, x[15:8], 0);
    cyc(1, x[23:16], 0);
    cyc(1, x[31:24], plast);
  endtask

  task automatic head(input string name, input logic [31:0] exp);
    chk(name, {data_out3, data_out2, data_out1, data_out0}, exp);
  endtask

  task automatic rst_pulse();
    @(negedge cclk);
    valid_in = 0;
    pop = 0;
    #2 reset_L = 0;
    #1;
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_lane", 32'(lane_ptr), 0);
    chk("rst_ovf", 32'(overflow), 0);
    head("rst_data", 0);
    #1 reset_L = 1;
  endtask

  initial begin
    rst_pulse();
    grp(32'h44332211, 0);
    cyc(0, 0, 0);
    chk("basic_valid", 32'(valid_out), 1);
    head("basic_data", 32'h44332211);
    chk("basic_count", 32'(fifo_count), 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("basic_pop_valid", 32'(valid_out), 0);
    chk("basic_pop_count", 32'(fifo_count), 0);

    cyc(1, 8'h11, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    chk("gap_lane1", 32'(lane_ptr), 1);
    cyc(1, 8'h22, 0); cyc(0, 0, 0);
    chk("gap_lane2", 32'(lane_ptr), 2);
    cyc(1, 8'h33, 0); cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    chk("gap_lane3", 32'(lane_ptr), 3);
    cyc(1, 8'h44, 0); cyc(0, 0, 0);
    head("gap_data", 32'h44332211);
    chk("gap_lane0", 32'(lane_ptr), 0);
    cyc(0, 0, 1); cyc(0, 0, 0);

    grp(32'hA3A2A1A0, 0);
    grp(32'hB3B2B1B0, 0);
    grp(32'hC3C2C1C0, 0);
    cyc(0, 0, 0);
    chk("ovf_count", 32'(fifo_count), 2);
    chk("ovf_flag", 32'(overflow), 1);
    head("ovf_head_a", 32'hA3A2A1A0);
    cyc(0, 0, 1); cyc(0, 0, 0);
    head("ovf_head_b", 32'hB3B2B1B0);
    chk("ovf_sticky", 32'(overflow), 1);
    cyc(0, 0, 1); cyc(0, 0, 0);
    chk("ovf_drained", 32'(valid_out), 0);

    rst_pulse();
    grp(32'hD3D2D1D0, 0);
    grp(32'hE3E2E1E0, 0);
    grp(32'hF3F2F1F0, 1);
    cyc(0, 0, 0);
    chk("full_pp_count", 32'(fifo_count), 2);
    chk("full_pp_ovf", 32'(overflow), 0);
    head("full_pp_head", 32'hE3E2E1E0);
    cyc(0, 0, 1); cyc(0, 0, 0);
    head("full_pp_third", 32'hF3F2F1F0);
    cyc(0, 0, 1);

    cyc(1, 8'h55, 0);
    cyc(1, 8'h66, 0);
    rst_pulse();
    grp(32'h04030201, 0);
    cyc(0, 0, 0);
    head("midrst_data", 32'h04030201);
    cyc(0, 0, 1);

    repeat (3000) cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0);
    rst_pulse();
    repeat (3000) begin
      if ($urandom_range(0, 499) == 0) rst_pulse();
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 0);
    end
    repeat (500) cyc(1, 8'($urandom), 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
